// File: rtl/comp_1bit_nor_unit_if.sv
// comp_1bit_nor_unit_if: sample/result bundle for the 1-bit NOR comparator.
//   a, b       compare operands
//   in_valid   sample strobe
//   cnt_clr    synchronous clear of the outcome counters
//   l, e, g    registered one-hot less/equal/greater flags
//   out_valid  one-cycle strobe after each accepted sample
//   cnt_l/e/g  saturating outcome counters, CNT_W bits each
// The master modport drives the samples. The slave modport is the comparator.
interface comp_1bit_nor_unit_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             a;
  logic             b;
  logic             in_valid;
  logic             cnt_clr;
  logic             l;
  logic             e;
  logic             g;
  logic             out_valid;
  logic [CNT_W-1:0] cnt_l;
  logic [CNT_W-1:0] cnt_e;
  logic [CNT_W-1:0] cnt_g;

  modport master (
    output a, b, in_valid, cnt_clr,
    input  l, e, g, out_valid, cnt_l, cnt_e, cnt_g
  );

  modport slave (
    input  a, b, in_valid, cnt_clr,
    output l, e, g, out_valid, cnt_l, cnt_e, cnt_g
  );
endinterface

// File: rtl/comp_1bit_nor_unit.sv
// comp_1bit_nor_unit: registered 1-bit magnitude comparator.
// The compare core is built only from 2-input NOR primitives.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    comp_1bit_nor_unit_if.slave
//          inputs:  a, b, in_valid, cnt_clr
//          outputs: l, e, g, out_valid, cnt_l, cnt_e, cnt_g
// An accepted sample loads the flags and bumps the matching counter one cycle
// later. Counters saturate at all-ones. cnt_clr takes priority over an increment.
module comp_1bit_nor_unit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  comp_1bit_nor_unit_if.slave  bus
);

  // NOR-only compare core
  logic nb, na, lt, gt, eq;

  nor u_nor_nb (nb, bus.b, bus.b);
  nor u_nor_na (na, bus.a, bus.a);
  nor u_nor_lt (lt, bus.a, nb);   // ~a & b
  nor u_nor_gt (gt, na, bus.b);   //  a & ~b
  nor u_nor_eq (eq, lt, gt);

  logic             l_q, e_q, g_q, out_valid_q;
  logic             l_d, e_d, g_d, out_valid_d;
  logic [CNT_W-1:0] cnt_l_q, cnt_e_q, cnt_g_q;
  logic [CNT_W-1:0] cnt_l_d, cnt_e_d, cnt_g_d;

  always_comb begin
    l_d         = l_q;
    e_d         = e_q;
    g_d         = g_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      l_d = lt;
      e_d = eq;
      g_d = gt;
    end
  end

  always_comb begin
    cnt_l_d = cnt_l_q;
    cnt_e_d = cnt_e_q;
    cnt_g_d = cnt_g_q;
    if (bus.cnt_clr) begin
      cnt_l_d = '0;
      cnt_e_d = '0;
      cnt_g_d = '0;
    end else if (bus.in_valid) begin
      // At most one of lt/eq/gt is high, so at most one counter moves.
      if (lt && (cnt_l_q != '1)) cnt_l_d = cnt_l_q + 1'b1;
      if (eq && (cnt_e_q != '1)) cnt_e_d = cnt_e_q + 1'b1;
      if (gt && (cnt_g_q != '1)) cnt_g_d = cnt_g_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q         <= 1'b0;
      e_q         <= 1'b0;
      g_q         <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_l_q     <= '0;
      cnt_e_q     <= '0;
      cnt_g_q     <= '0;
    end else begin
      l_q         <= l_d;
      e_q         <= e_d;
      g_q         <= g_d;
      out_valid_q <= out_valid_d;
      cnt_l_q     <= cnt_l_d;
      cnt_e_q     <= cnt_e_d;
      cnt_g_q     <= cnt_g_d;
    end
  end

  assign bus.l         = l_q;
  assign bus.e         = e_q;
  assign bus.g         = g_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cnt_l     = cnt_l_q;
  assign bus.cnt_e     = cnt_e_q;
  assign bus.cnt_g     = cnt_g_q;

endmodule

// File: tb/tb_comp_1bit_nor_unit.sv
// tb_comp_1bit_nor_unit: drives comp_1bit_nor_unit with directed and random
// samples, and compares every output against an arithmetic reference model.
module tb_comp_1bit_nor_unit;

  localparam int unsigned CNT_W = 8;
  localparam int          MAXC  = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  comp_1bit_nor_unit_if #(.CNT_W(CNT_W)) bus ();

  comp_1bit_nor_unit #(.CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model state
  int m_l, m_e, m_g, m_ov;
  int m_cl, m_ce, m_cg;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_l  = 0;
    m_e  = 0;
    m_g  = 0;
    m_ov = 0;
    m_cl = 0;
    m_ce = 0;
    m_cg = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".l"},   int'(bus.l),         m_l);
    check({tag, ".e"},   int'(bus.e),         m_e);
    check({tag, ".g"},   int'(bus.g),         m_g);
    check({tag, ".ov"},  int'(bus.out_valid), m_ov);
    check({tag, ".cnl"}, int'(bus.cnt_l),     m_cl);
    check({tag, ".cne"}, int'(bus.cnt_e),     m_ce);
    check({tag, ".cng"}, int'(bus.cnt_g),     m_cg);
  endtask

  // Drive one cycle of stimulus at negedge, update the model at the posedge,
  // then check the outputs 1ns later.
  task automatic step(input int ai, input int bi, input int vi, input int ci,
                      input string tag);
    @(negedge clk);
    bus.a        = 1'(ai);
    bus.b        = 1'(bi);
    bus.in_valid = 1'(vi);
    bus.cnt_clr  = 1'(ci);
    @(posedge clk);
    if (vi != 0) begin
      m_l  = (ai < bi)  ? 1 : 0;
      m_e  = (ai == bi) ? 1 : 0;
      m_g  = (ai > bi)  ? 1 : 0;
      m_ov = 1;
    end else begin
      m_ov = 0;
    end
    if (ci != 0) begin
      m_cl = 0;
      m_ce = 0;
      m_cg = 0;
    end else if (vi != 0) begin
      if (ai < bi)  m_cl = (m_cl < MAXC) ? m_cl + 1 : MAXC;
      if (ai == bi) m_ce = (m_ce < MAXC) ? m_ce + 1 : MAXC;
      if (ai > bi)  m_cg = (m_cg < MAXC) ? m_cg + 1 : MAXC;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.a        = 1'b0;
    bus.b        = 1'b0;
    bus.in_valid = 1'b0;
    bus.cnt_clr  = 1'b0;
    model_reset();

    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed truth-table sequence, back to back
    step(0, 0, 1, 0, "tt00");
    step(0, 1, 1, 0, "tt01");
    step(1, 0, 1, 0, "tt10");
    step(1, 1, 1, 0, "tt11");
    check("cnt_l_after_tt", int'(bus.cnt_l), 1);
    check("cnt_e_after_tt", int'(bus.cnt_e), 2);
    check("cnt_g_after_tt", int'(bus.cnt_g), 1);

    // Hold while invalid
    step(1, 0, 1, 0, "gt_load");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "hold");
    check("hold_g", int'(bus.g), 1);

    // Clear, then saturate cnt_l
    step(0, 0, 0, 1, "clr_idle");
    for (int i = 0; i < 300; i++) step(0, 1, 1, 0, "sat");
    check("sat_cnt_l", int'(bus.cnt_l), 255);

    // Clear beats increment of a saturated counter
    step(0, 1, 1, 1, "clr_sat");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, "regrow");
    step(1, 1, 1, 1, "clr_eq");
    check("clr_eq_e", int'(bus.e), 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           ($urandom_range(0, 31) == 0) ? 1 : 0, "rand");
    end

    // Asynchronous reset mid-stream
    step(1, 0, 1, 0, "pre_rst");
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cnt_clr  = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 0, 0, "post_rst_idle");
    step(0, 1, 1, 0, "post_rst");
    check("post_rst_cnt_l", int'(bus.cnt_l), 1);

    // Exhaustive sweep
    for (int i = 0; i < 4; i++) step(i / 2, i % 2, 1, 0, "sweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound the run so it always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
